// File: rtl/arbitro_pkg.sv
// Shared definitions for the round-robin queue arbiter: controller state codes,
// stall-mode encodings and a width helper.
package arbitro_pkg;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } ctrl_state_t;

    localparam int STALL_GLOBAL   = 0;
    localparam int STALL_PER_DEST = 1;

    // ceil(log2(n)), never below 1 so that 1-bit fields stay legal
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/arbitro_rr_n_rr_select.sv
// Rotating-priority selector: picks the first requester at or after ptr,
// wrapping from N-1 back to 0.
module rr_select
    import arbitro_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic             valid
);

    int idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_n.sv
// Round-robin arbiter moving head words from NUM_CH source FIFOs to the
// destination FIFO named in each word's top bits, with almost_full back-pressure.
module arbitro_rr_n
    import arbitro_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 6,
    parameter int STALL_MODE = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [3:0]               state,
    input  logic [NUM_CH-1:0]        empty,
    input  logic [NUM_CH*DATA_W-1:0] data_in,
    input  logic [NUM_CH-1:0]        almost_full,
    output logic [NUM_CH-1:0]        pop,
    output logic [NUM_CH-1:0]        push,
    output logic [DATA_W-1:0]        data_out
);

    localparam int DEST_W = clog2(NUM_CH);
    localparam int PTR_W  = clog2(NUM_CH);

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] grant;
    logic              grant_valid;
    logic              enable;
    logic              stall_all;
    logic [DEST_W-1:0] dest [NUM_CH];
    logic [NUM_CH-1:0] push_next;
    logic [DATA_W-1:0] data_next;

    assign enable    = (state == ST_IDLE) || (state == ST_ACTIVE);
    assign stall_all = (STALL_MODE == STALL_GLOBAL) && (|almost_full);

    // Destination fields beyond NUM_CH-1 can only occur for non-power-of-2
    // NUM_CH; such words are never eligible.
    always_comb begin
        req = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            dest[i] = data_in[i*DATA_W + DATA_W - DEST_W +: DEST_W];
            if (enable && !stall_all && !empty[i] && (int'(dest[i]) < NUM_CH))
                req[i] = !almost_full[dest[i]];
        end
    end

    rr_select #(
        .N     (NUM_CH),
        .PTR_W (PTR_W)
    ) u_rr_select (
        .req   (req),
        .ptr   (rr_ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    assign pop = reset ? '0 : grant;

    always_comb begin
        push_next = '0;
        data_next = '0;
        ptr_next  = rr_ptr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                push_next[dest[i]] = 1'b1;
                data_next          = data_in[i*DATA_W +: DATA_W];
                ptr_next           = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
            end
        end
    end

    // Async reset also swallows a push whose grant was already issued.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            push     <= '0;
            data_out <= '0;
        end else begin
            rr_ptr <= ptr_next;
            push   <= push_next;
            if (grant_valid) data_out <= data_next;
        end
    end

endmodule

// File: tb/tb_arbitro_rr_n.sv
// Scoreboard bench for arbitro_rr_n: one instance per stall mode sharing the
// same stimulus; expected pushes are queued at grant time and matched by a monitor.
module tb_arbitro_rr_n;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [3:0]  empty;
    logic [3:0]  almost_full;
    logic [5:0]  din [4];
    logic [23:0] data_in;
    logic [3:0]  pop0, pop1, push0, push1;
    logic [5:0]  dout0, dout1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] push;
        logic [5:0] data;
    } exp_t;

    exp_t       q0[$];
    exp_t       q1[$];
    logic [5:0] last0, last1;

    assign data_in = {din[3], din[2], din[1], din[0]};

    always #5 clk = ~clk;

    arbitro_rr_n #(.NUM_CH(4), .DATA_W(6), .STALL_MODE(0)) dut0 (
        .clk(clk), .reset(reset), .state(state), .empty(empty), .data_in(data_in),
        .almost_full(almost_full), .pop(pop0), .push(push0), .data_out(dout0)
    );

    arbitro_rr_n #(.NUM_CH(4), .DATA_W(6), .STALL_MODE(1)) dut1 (
        .clk(clk), .reset(reset), .state(state), .empty(empty), .data_in(data_in),
        .almost_full(almost_full), .pop(pop1), .push(push1), .data_out(dout1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model of the push that a grant must produce one edge later.
    task automatic expect_grant(input int inst, input logic [3:0] g);
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            if (g[i]) begin
                e.push = 4'b0001 << din[i][5:4];
                e.data = din[i];
                if (inst == 0) begin q0.push_back(e); last0 = e.data; end
                else           begin q1.push_back(e); last1 = e.data; end
            end
        end
    endtask

    task automatic step(input logic [3:0] st, input logic [3:0] emp, input logic [3:0] af,
                        input logic [3:0] p0, input logic [3:0] p1);
        state       = st;
        empty       = emp;
        almost_full = af;
        @(negedge clk);
        chk("pop_mode0", pop0, p0);
        chk("pop_mode1", pop1, p1);
        expect_grant(0, p0);
        expect_grant(1, p1);
        @(posedge clk);
        #1;
        if (p0 == 4'b0000) begin
            chk("push_idle_mode0", push0, 4'b0000);
            chk("dout_hold_mode0", dout0, last0);
        end
        if (p1 == 4'b0000) begin
            chk("push_idle_mode1", push1, 4'b0000);
            chk("dout_hold_mode1", dout1, last1);
        end
    endtask

    task automatic dests_ascending();
        for (int i = 0; i < 4; i++) din[i] = {2'(i), 4'(i * 3 + 1)};
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (push0 != 4'b0000) begin
            if (q0.size() == 0) begin
                checks++; errors++;
                $display("FAIL push_unexpected_mode0 got %0h expected none at %0t", push0, $time);
            end else begin
                e = q0.pop_front();
                chk("push_mode0", push0, e.push);
                chk("data_out_mode0", dout0, e.data);
            end
        end
        if (push1 != 4'b0000) begin
            if (q1.size() == 0) begin
                checks++; errors++;
                $display("FAIL push_unexpected_mode1 got %0h expected none at %0t", push1, $time);
            end else begin
                e = q1.pop_front();
                chk("push_mode1", push1, e.push);
                chk("data_out_mode1", dout1, e.data);
            end
        end
    end

    initial begin
        reset       = 1'b1;
        state       = 4'b1000;
        empty       = 4'b0000;
        almost_full = 4'b0000;
        last0       = '0;
        last1       = '0;
        dests_ascending();

        // reset held with everything pending
        repeat (2) begin
            @(negedge clk);
            chk("rst_pop_mode0", pop0, 4'b0000);
            chk("rst_pop_mode1", pop1, 4'b0000);
            chk("rst_push_mode0", push0, 4'b0000);
            chk("rst_push_mode1", push1, 4'b0000);
            chk("rst_dout_mode0", dout0, 6'h00);
        end
        @(posedge clk);
        #1 reset = 1'b0;

        // full rotation, first grant is source 0
        step(4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        step(4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0010);
        step(4'b1000, 4'b0000, 4'b0000, 4'b0100, 4'b0100);
        step(4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b1000);
        step(4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);

        // destination 2 almost full: global stall vs per-destination skip
        step(4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0010);
        step(4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b1000);
        step(4'b1000, 4'b0000, 4'b0100, 4'b0000, 4'b0001);
        step(4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b0010);

        // all empty, then only source 3 to bring the pointer back to 0
        step(4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step(4'b1000, 4'b0111, 4'b0000, 4'b1000, 4'b1000);

        // source 0 -> dest 2 (blocked), source 1 -> dest 3
        din[0] = {2'd2, 4'hA};
        din[1] = {2'd3, 4'h5};
        step(4'b1000, 4'b1100, 4'b0100, 4'b0000, 4'b0010);
        step(4'b1000, 4'b1100, 4'b0000, 4'b0001, 4'b0001);
        // almost_full rising after a grant must not cancel its push
        step(4'b1000, 4'b1100, 4'b1111, 4'b0000, 4'b0000);

        // disabled controller states, then IDLE grants immediately
        dests_ascending();
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        step(4'b0100, 4'b0000, 4'b0000, 4'b0010, 4'b0010);

        // reset pulsed in a grant cycle discards the push and clears the pointer
        state = 4'b1000;
        @(negedge clk);
        chk("pre_rst_pop_mode0", pop0, 4'b0100);
        chk("pre_rst_pop_mode1", pop1, 4'b0100);
        #1 reset = 1'b1;
        #1;
        chk("rst_async_pop_mode0", pop0, 4'b0000);
        chk("rst_async_pop_mode1", pop1, 4'b0000);
        @(posedge clk);
        #1;
        chk("rst_nopush_mode0", push0, 4'b0000);
        chk("rst_nopush_mode1", push1, 4'b0000);
        chk("rst_dout_clr_mode1", dout1, 6'h00);
        last0 = '0;
        last1 = '0;
        @(posedge clk);
        #1 reset = 1'b0;
        step(4'b1000, 4'b0000, 4'b0000, 4'b0001, 4'b0001);
        step(4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);
        step(4'b1000, 4'b1111, 4'b0000, 4'b0000, 4'b0000);

        chk("pending_pushes_mode0", 32'(q0.size()), 32'd0);
        chk("pending_pushes_mode1", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
